// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream bus carrying generated test packets, with an empty-count sideband
// and an incomplete-packet marker on the last beat.
interface axis_pkt_gen_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MTY_WIDTH  = 8
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic [MTY_WIDTH-1:0]  tuser_mty;
  logic                  drop_incmpt_pkt;
  logic                  tready;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser_mty,
    output drop_incmpt_pkt,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser_mty,
    input  drop_incmpt_pkt,
    output tready
  );
endinterface

// File: rtl/axis_pkt_gen.sv
// Numbered test-packet generator for the packet queue. Beats carry an incrementing
// byte pattern; the last beat carries (packet index + 1) as empty count and,
// optionally, the incomplete-packet marker. All outputs come straight from flops.
module axis_pkt_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MTY_WIDTH  = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_pkt_len,
  input  logic [LEN_WIDTH-1:0] cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic                 cfg_bad_en,
  input  logic [LEN_WIDTH-1:0] cfg_bad_idx,
  axis_pkt_gen_if.master       m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] pkt_cnt
);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e                state_q, state_d;

  // Shadow copies of the configuration, captured on an accepted start.
  logic [LEN_WIDTH-1:0]  len_last_q;
  logic [LEN_WIDTH-1:0]  num_q;
  logic [GAP_WIDTH-1:0]  gap_cfg_q;
  logic                  bad_en_q;
  logic [LEN_WIDTH-1:0]  bad_idx_q;

  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  pkt_idx_q, pkt_idx_d;
  logic [LEN_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;

  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic [MTY_WIDTH-1:0]  mty_q, mty_d;
  logic                  drop_q, drop_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  start_acc;
  logic                  final_pkt;
  logic                  load;
  logic [LEN_WIDTH-1:0]  ld_beat;
  logic [LEN_WIDTH-1:0]  ld_pkt;
  logic [LEN_WIDTH-1:0]  beat_num;
  logic [LEN_WIDTH-1:0]  pkt_num;
  logic                  ld_last;

  assign start_acc = (state_q == StIdle) && start;
  assign final_pkt = (num_q != '0) && (pkt_idx_q == num_q - LEN_WIDTH'(1));

  // Configuration shadow registers; a length of 0 behaves as 1.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_last_q <= '0;
      num_q      <= '0;
      gap_cfg_q  <= '0;
      bad_en_q   <= 1'b0;
      bad_idx_q  <= '0;
    end else if (start_acc) begin
      len_last_q <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_WIDTH'(1);
      num_q      <= cfg_num_pkts;
      gap_cfg_q  <= cfg_gap;
      bad_en_q   <= cfg_bad_en;
      bad_idx_q  <= cfg_bad_idx;
    end
  end

  // State, counters and registered bus outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      pkt_idx_q <= '0;
      pkt_cnt_q <= '0;
      gap_q     <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      mty_q     <= '0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pkt_idx_q <= pkt_idx_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_q     <= gap_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      mty_q     <= mty_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state, counters and next beat contents; a "load" presents beat ld_beat
  // of packet ld_pkt on the following cycle.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pkt_idx_d = pkt_idx_q;
    pkt_cnt_d = pkt_cnt_q;
    gap_d     = gap_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    mty_d     = mty_q;
    drop_d    = drop_q;
    done_d    = 1'b0;
    load      = 1'b0;
    ld_beat   = beat_q;
    ld_pkt    = pkt_idx_q;
    beat_num  = '0;
    pkt_num   = '0;
    ld_last   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSend;
          beat_d    = '0;
          pkt_idx_d = '0;
          pkt_cnt_d = '0;
        end
      end
      StSend: begin
        if (!tvalid_q) begin
          // First beat of a run: shadow config is valid from this cycle on.
          load = 1'b1;
        end else if (m_axis.tready) begin
          if (!tlast_q) begin
            beat_d  = beat_q + LEN_WIDTH'(1);
            ld_beat = beat_d;
            load    = 1'b1;
          end else begin
            beat_d    = '0;
            pkt_idx_d = pkt_idx_q + LEN_WIDTH'(1);
            pkt_cnt_d = pkt_cnt_q + LEN_WIDTH'(1);
            tvalid_d  = 1'b0;
            if (stop || final_pkt) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (gap_cfg_q != '0) begin
              state_d = StGap;
              gap_d   = gap_cfg_q;
            end else begin
              ld_beat = '0;
              ld_pkt  = pkt_idx_d;
              load    = 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (stop) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (gap_q <= GAP_WIDTH'(1)) begin
          // Loading on the last gap cycle leaves exactly gap_cfg_q idle cycles.
          state_d = StSend;
          load    = 1'b1;
        end else begin
          gap_d = gap_q - GAP_WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      beat_num = ld_beat + LEN_WIDTH'(1);
      pkt_num  = ld_pkt + LEN_WIDTH'(1);
      ld_last  = (ld_beat == len_last_q);
      tvalid_d = 1'b1;
      tdata_d  = DATA_WIDTH'(beat_num);
      tlast_d  = ld_last;
      mty_d    = ld_last ? MTY_WIDTH'(pkt_num) : '0;
      drop_d   = ld_last && bad_en_q && (ld_pkt == bad_idx_q);
    end else if (!tvalid_d) begin
      tdata_d = '0;
      tlast_d = 1'b0;
      mty_d   = '0;
      drop_d  = 1'b0;
    end

    // Rises one cycle after the start edge, drops as the FSM re-enters idle.
    busy_d = (state_q != StIdle) && (state_q != StDone);
  end

  assign m_axis.tvalid          = tvalid_q;
  assign m_axis.tdata           = tdata_q;
  assign m_axis.tlast           = tlast_q;
  assign m_axis.tuser_mty       = mty_q;
  assign m_axis.drop_incmpt_pkt = drop_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign pkt_cnt                = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: expected beats and gaps are queued when a
// run is launched and consumed by a monitor as the DUT transfers beats.
module tb_axis_pkt_gen;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned GW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [LW-1:0] cfg_pkt_len = '0;
  logic [LW-1:0] cfg_num_pkts = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic          cfg_bad_en = 1'b0;
  logic [LW-1:0] cfg_bad_idx = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] pkt_cnt;

  axis_pkt_gen_if #(.DATA_WIDTH(DW), .MTY_WIDTH(MW)) axis ();

  axis_pkt_gen #(
    .DATA_WIDTH(DW),
    .MTY_WIDTH (MW),
    .LEN_WIDTH (LW),
    .GAP_WIDTH (GW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .start       (start),
    .stop        (stop),
    .cfg_pkt_len (cfg_pkt_len),
    .cfg_num_pkts(cfg_num_pkts),
    .cfg_gap     (cfg_gap),
    .cfg_bad_en  (cfg_bad_en),
    .cfg_bad_idx (cfg_bad_idx),
    .m_axis      (axis),
    .busy        (busy),
    .done        (done),
    .pkt_cnt     (pkt_cnt)
  );

  always #5 aclk = ~aclk;

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat packed as {drop, last, mty, data}.
  logic [17:0] exp_q[$];
  int          gap_q[$];
  logic [17:0] cur_beat;
  assign cur_beat = {axis.drop_incmpt_pkt, axis.tlast, axis.tuser_mty, axis.tdata};

  bit mon_en = 1'b0;
  bit rdy_toggle = 1'b0;
  int cyc = 0;
  int run_xfers = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  int last_tlast_cyc = 0;

  // Sink ready: constant high or toggling every cycle.
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      axis.tready = rdy_toggle ? ~axis.tready : 1'b1;
    end
  end

  // Monitor: scoreboard compare, stability while stalled, gaps and done timing.
  initial begin
    bit          hold_valid;
    bit          after_tlast;
    logic [17:0] held;
    logic [31:0] e;
    int          g;
    hold_valid  = 1'b0;
    after_tlast = 1'b0;
    held        = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn || !mon_en) begin
        hold_valid  = 1'b0;
        after_tlast = 1'b0;
        if (aresetn && axis.tvalid && axis.tready) run_xfers++;
      end else begin
        if (done) begin
          check_eq("done_after_tlast", cyc - 1, last_tlast_cyc);
          after_tlast = 1'b0;
        end
        if (axis.tvalid) begin
          if (hold_valid) check_eq("stable", cur_beat, held);
          if (after_tlast) begin
            g = (gap_q.size() != 0) ? gap_q.pop_front() : -1;
            check_eq("gap", cyc - last_tlast_cyc - 1, g);
            after_tlast = 1'b0;
          end
          if (axis.tready) begin
            e = (exp_q.size() != 0) ? {14'd0, exp_q.pop_front()} : 'x;
            check_eq("beat", cur_beat, e);
            run_xfers++;
            if (run_xfers == 1) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            if (axis.tlast) begin
              last_tlast_cyc = cyc;
              after_tlast    = 1'b1;
            end
            hold_valid = 1'b0;
          end else begin
            hold_valid = 1'b1;
            held       = cur_beat;
          end
        end else if (hold_valid) begin
          check_eq("valid_dropped", axis.tvalid, 1);
          hold_valid = 1'b0;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    check_eq({name, "_tvalid"}, axis.tvalid, 0);
    check_eq({name, "_tdata"}, axis.tdata, 0);
    check_eq({name, "_tlast"}, axis.tlast, 0);
    check_eq({name, "_mty"}, axis.tuser_mty, 0);
    check_eq({name, "_drop"}, axis.drop_incmpt_pkt, 0);
    check_eq({name, "_busy"}, busy, 0);
    check_eq({name, "_done"}, done, 0);
    check_eq({name, "_pkt_cnt"}, pkt_cnt, 0);
  endtask

  // Launch one run, queue its expected beats/gaps, wait for done and check the end state.
  task automatic run(input int len, input int num, input int gap, input bit bad_en,
                     input int bad_idx, input bit toggle, input int n_exp,
                     input int stop_after, input string name);
    int eff;
    int c;
    bit done_seen;
    eff = (len == 0) ? 1 : len;
    for (int p = 0; p < n_exp; p++) begin
      for (int k = 0; k < eff; k++) begin
        bit last;
        bit drop;
        int d;
        int m;
        last = (k == eff - 1);
        drop = last && bad_en && (p == bad_idx);
        d    = (k + 1) % 256;
        m    = last ? (p + 1) % 256 : 0;
        exp_q.push_back({drop, last, 8'(m), 8'(d)});
      end
    end
    for (int p = 0; p < n_exp - 1; p++) gap_q.push_back(gap);

    rdy_toggle   = toggle;
    run_xfers    = 0;
    cfg_pkt_len  = LW'(len);
    cfg_num_pkts = LW'(num);
    cfg_gap      = GW'(gap);
    cfg_bad_en   = bad_en;
    cfg_bad_idx  = LW'(bad_idx);

    @(posedge aclk);
    #1 start = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    check_eq({name, "_valid_lat0"}, axis.tvalid, 0);
    check_eq({name, "_busy_lat0"}, busy, 0);
    // Scrambled config and a second start must not affect the run in progress.
    cfg_pkt_len  = LW'($urandom_range(1, 3));
    cfg_num_pkts = LW'($urandom_range(1, 2));
    cfg_gap      = GW'($urandom_range(1, 7));
    cfg_bad_en   = ~bad_en;
    cfg_bad_idx  = '0;
    @(posedge aclk);
    #1;
    check_eq({name, "_valid_lat1"}, axis.tvalid, 1);
    check_eq({name, "_busy_lat1"}, busy, 1);
    start = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;

    done_seen = done;
    c = 0;
    while (!done_seen && c < 3000) begin
      @(posedge aclk);
      #1;
      if (stop_after != 0 && run_xfers >= stop_after) stop = 1'b1;
      done_seen = done;
      c++;
    end
    check_eq({name, "_done_seen"}, done_seen, 1);
    check_eq({name, "_pkt_cnt"}, pkt_cnt, n_exp);
    check_eq({name, "_busy_in_done"}, busy, 1);
    stop = 1'b0;
    @(posedge aclk);
    #1;
    check_eq({name, "_busy_after"}, busy, 0);
    check_eq({name, "_done_pulse"}, done, 0);
    check_eq({name, "_xfers"}, run_xfers, n_exp * eff);
    check_eq({name, "_sb_left"}, exp_q.size(), 0);
    check_eq({name, "_gaps_left"}, gap_q.size(), 0);
    if (!toggle && gap == 0) check_eq({name, "_contig"}, last_xfer_cyc - first_xfer_cyc + 1, n_exp * eff);
    exp_q.delete();
    gap_q.delete();
    rdy_toggle = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(posedge aclk);
    #1;
    check_idle_outputs("reset");
    aresetn = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(posedge aclk);

    run(13, 1, 0, 1'b0, 0, 1'b0, 1, 0, "one_pkt");
    run(13, 5, 0, 1'b1, 3, 1'b0, 5, 0, "five_pkt");
    run(4, 3, 3, 1'b0, 0, 1'b1, 3, 0, "gap_stall");
    run(6, 0, 0, 1'b0, 0, 1'b0, 3, 15, "stop");

    // Reset in the middle of a packet, then restart from scratch.
    mon_en       = 1'b0;
    run_xfers    = 0;
    cfg_pkt_len  = LW'(10);
    cfg_num_pkts = LW'(1);
    cfg_gap      = '0;
    cfg_bad_en   = 1'b0;
    @(posedge aclk);
    #1 start = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    c = 0;
    while (run_xfers < 6 && c < 100) begin
      @(posedge aclk);
      #1;
      c++;
    end
    check_eq("pre_rst_data", axis.tdata, 7);
    #1 aresetn = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    exp_q.delete();
    gap_q.delete();
    mon_en = 1'b1;
    run(3, 1, 0, 1'b0, 0, 1'b0, 1, 0, "post_rst");

    run(0, 3, 0, 1'b0, 0, 1'b0, 3, 0, "len0");

    repeat (3) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Synthesizable AXI-Stream packet transmitter that drives the slave side of the packet queue with numbered test packets. Each packet carries an incrementing byte pattern, an end-of-packet empty count on `tuser_mty`, and an optional incomplete-packet marker on its last beat. The block sits in front of the queue in bring-up and loopback builds and replaces the hand-written stimulus once the design runs on hardware.

## Interface
- `DATA_WIDTH`, 8, width of `m_axis_tdata`
- `MTY_WIDTH`, 8, width of `m_axis_tuser_mty`
- `LEN_WIDTH`, 16, width of the packet-length and packet-count fields
- `GAP_WIDTH`, 8, width of the inter-packet gap field
- `aclk`  in  1  single clock; all logic on the rising edge
- `aresetn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `stop`  in  1  level; finish the current packet, then end the run
- `cfg_pkt_len`  in  LEN_WIDTH  beats per packet; 0 is treated as 1
- `cfg_num_pkts`  in  LEN_WIDTH  packets per run; 0 means continuous until `stop`
- `cfg_gap`  in  GAP_WIDTH  idle cycles between packets; 0 means back-to-back
- `cfg_bad_en`  in  1  enables the incomplete-packet marker
- `cfg_bad_idx`  in  LEN_WIDTH  packet index (from 0) that gets the marker
- `m_axis_tvalid`  out  1  beat valid
- `m_axis_tdata`  out  DATA_WIDTH  payload byte
- `m_axis_tlast`  out  1  last beat of a packet
- `m_axis_tuser_mty`  out  MTY_WIDTH  empty count; nonzero only on the tlast beat
- `m_axis_tready`  in  1  sink ready
- `m_drop_incmpt_pkt`  out  1  marks the tlast beat of the bad packet
- `busy`  out  1  high from the cycle after `start` until DONE
- `done`  out  1  one-cycle pulse at the end of a run
- `pkt_cnt`  out  LEN_WIDTH  packets fully accepted in the current or last run

## Operation
- All `cfg_*` inputs are latched into shadow registers on an accepted `start`. Changes during a run have no effect.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE & `start` -> SEND. Clears the beat index, the packet index and `pkt_cnt`.
  - SEND: a beat transfers when `tvalid & tready`.
  - On a transfer of a beat that is not last, the beat index increments.
  - On a transfer of a tlast beat, the packet index and `pkt_cnt` increment. Next state:
    - DONE if `stop` is high, or if `cfg_num_pkts` is nonzero and this was packet `cfg_num_pkts`-1;
    - otherwise GAP if `cfg_gap` is nonzero;
    - otherwise SEND.
  - GAP: counts `cfg_gap` cycles with `tvalid` low, then -> SEND.
  - DONE: one cycle, `done` = 1, then -> IDLE.
- Beat contents:
  - Beat k (k = 0 .. len-1) carries `tdata` = (k+1) mod 2^DATA_WIDTH.
  - `tlast` = 1 when k = len-1.
  - On the tlast beat, `tuser_mty` = (packet index + 1) mod 2^MTY_WIDTH; on every other beat it is 0.
- `m_drop_incmpt_pkt` = 1 only on the tlast beat of packet `cfg_bad_idx`, and only when `cfg_bad_en` is set. Otherwise it is 0.
- `stop` raised in GAP or IDLE -> DONE (from GAP) on the next cycle. `stop` never truncates a packet in flight.
- The packet index wraps at 2^LEN_WIDTH when running continuously; `pkt_cnt` wraps the same way.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE.
  - `m_axis_tvalid`, `tlast`, `tdata`, `tuser_mty`, `m_drop_incmpt_pkt`, `busy`, `done` all reset to 0.
  - `pkt_cnt` resets to 0 and all counters clear.
- Reset asserted mid-packet drops `tvalid` at once. No recovery of a partial packet.
- Every output is registered.
- `start` sampled at edge t -> first beat has `tvalid` = 1 after edge t+1. `busy` = 1 from edge t+1.
- AXI rule: once `tvalid` is 1, `tvalid`, `tdata`, `tlast`, `tuser_mty` and `m_drop_incmpt_pkt` hold stable until the transfer. `tvalid` never depends combinationally on `tready`.
- Sustained rate is one beat per cycle with `tready` = 1 and `cfg_gap` = 0. Consecutive packets then have no idle cycle between them.
- With `cfg_gap` = G, exactly G cycles with `tvalid` = 0 separate the tlast transfer from the next first beat.
- `done` rises the cycle after the final tlast transfer. `busy` falls with the return to IDLE.
- `start` while `busy` is ignored.

## Test plan
- Length 13, 1 packet, `tready` = 1 -> beats 0x01..0x0D on 13 consecutive cycles, tlast on 0x0D with mty 0x01, then `done` pulses and `pkt_cnt` = 1.
- Length 13, 5 packets, gap 0, `cfg_bad_en` = 1, `cfg_bad_idx` = 3 -> 65 contiguous beats, tlast mty 1,2,3,4,5, `m_drop_incmpt_pkt` = 1 only on the 4th tlast beat.
- Length 4, gap 3, `tready` toggling every cycle -> every beat held stable while stalled, exactly 3 idle cycles after each tlast transfer, no beat lost or duplicated.
- `cfg_num_pkts` = 0, `stop` raised mid-way through packet 2 -> packet 2 completes, `done` pulses, `pkt_cnt` = 3.
- `aresetn` pulsed low at beat 6 of a packet -> all outputs 0 immediately. A new `start` then gives 0x01 as the first beat and `pkt_cnt` restarts at 0.
- `cfg_pkt_len` = 0 -> single-beat packets, each with `tdata` 0x01 and tlast = 1.
